// File: rtl/traffic_countdown_display_pkg.sv
// traffic_pkg: shared types and constants for the traffic countdown display.
//   scan_state_e : digit scan sequence (units, gap, tens, gap)
//   SEG_*        : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   CNT_W        : width of the per-light countdown values
//   bcd_split    : 5-bit value -> {tens, units}, both 4-bit BCD
package traffic_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    S_UNITS,
    S_GAP1,
    S_TENS,
    S_GAP2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Range compare instead of a divider: the value never exceeds 31.
  function automatic logic [7:0] bcd_split(input logic [CNT_W-1:0] v);
    logic [3:0] t;
    logic [3:0] u;
    if (v >= 5'd30) begin
      t = 4'd3;
      u = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      t = 4'd2;
      u = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      t = 4'd1;
      u = 4'(v - 5'd10);
    end else begin
      t = 4'd0;
      u = 4'(v);
    end
    return {t, u};
  endfunction

endpackage

// File: rtl/traffic_countdown_display_seg7_decode.sv
// seg7_decode: combinational BCD to seven-segment decoder.
//   bcd_i   : 4-bit BCD digit (10..15 decode to blank)
//   blank_i : force all segments off
//   seg_n_o : segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: two-digit multiplexed countdown display driven
// by the traffic-light controller outputs.
//   clk, rst                 : clock, synchronous active-low reset
//   red, green, yellow       : light state (one-hot when legal)
//   count_red/green/yellow   : remaining seconds per light, 0..31
//   seg_n                    : active-low segments {g,f,e,d,c,b,a}, registered
//   an_n                     : active-low digit enables, [0]=units [1]=tens
//   fault                    : light state not one-hot, registered
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned BLINK_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic [CNT_W-1:0] count_red,
  input  logic [CNT_W-1:0] count_green,
  input  logic [CNT_W-1:0] count_yellow,
  output logic [6:0]       seg_n,
  output logic [1:0]       an_n,
  output logic             fault
);

  localparam int unsigned DWELL_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Input stage
  logic             red_q, green_q, yellow_q;
  logic [CNT_W-1:0] cnt_red_q, cnt_green_q, cnt_yellow_q;

  // Scan, blink and output registers
  scan_state_e      state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_on_q, phase_on_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             fault_q;

  logic             is_fault;
  logic             is_gap;
  logic             blink_on;
  logic [CNT_W-1:0] value;
  logic [3:0]       tens, units;
  logic [3:0]       dig;
  logic             dig_blank;
  logic [6:0]       dec_seg;

  assign is_fault = !({red_q, green_q, yellow_q} inside {3'b100, 3'b010, 3'b001});
  assign is_gap   = (state_q == S_GAP1) || (state_q == S_GAP2);
  assign blink_on = yellow_q && !is_fault;

  always_comb begin
    value = cnt_yellow_q;
    if (red_q) begin
      value = cnt_red_q;
    end else if (green_q) begin
      value = cnt_green_q;
    end
  end

  assign {tens, units} = bcd_split(value);

  // Single decoder shared by both digits; gaps reuse its blank path.
  always_comb begin
    dig       = units;
    dig_blank = 1'b0;
    case (state_q)
      S_UNITS: begin
        dig       = units;
        dig_blank = 1'b0;
      end
      S_TENS: begin
        dig       = tens;
        dig_blank = (tens == 4'd0);
      end
      default: begin
        dig       = units;
        dig_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_dec (
    .bcd_i   (dig),
    .blank_i (dig_blank),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    if (is_gap) begin
      seg_d = SEG_BLANK;
    end else if (is_fault) begin
      seg_d = SEG_DASH;
    end else if (blink_on && !phase_on_q) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg;
    end
  end

  always_comb begin
    case (state_q)
      S_UNITS: an_d = 2'b10;
      S_TENS:  an_d = 2'b01;
      default: an_d = 2'b11;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + 1'b1;
    case (state_q)
      S_UNITS: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_GAP1;
          dwell_d = '0;
        end
      end
      S_GAP1: begin
        state_d = S_TENS;
        dwell_d = '0;
      end
      S_TENS: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_GAP2;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = S_UNITS;
        dwell_d = '0;
      end
    endcase
  end

  // Holding the counter at 0/ON outside yellow makes the first yellow
  // cycle restart the blink without a separate edge detector.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_on_d  = phase_on_q;
    if (!blink_on) begin
      blink_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_on_d  = !phase_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      red_q        <= 1'b0;
      green_q      <= 1'b0;
      yellow_q     <= 1'b0;
      cnt_red_q    <= '0;
      cnt_green_q  <= '0;
      cnt_yellow_q <= '0;
      state_q      <= S_UNITS;
      dwell_q      <= '0;
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
      seg_q        <= SEG_BLANK;
      an_q         <= 2'b11;
      fault_q      <= 1'b0;
    end else begin
      red_q        <= red;
      green_q      <= green;
      yellow_q     <= yellow;
      cnt_red_q    <= count_red;
      cnt_green_q  <= count_green;
      cnt_yellow_q <= count_yellow;
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fault_q      <= is_fault;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
module tb_traffic_countdown_display;

  localparam int R = 4;
  localparam int B = 8;
  localparam int P = 2 * R + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       red, green, yellow;
  logic [4:0] count_red, count_green, count_yellow;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_countdown_display #(
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red          (red),
    .green        (green),
    .yellow       (yellow),
    .count_red    (count_red),
    .count_green  (count_green),
    .count_yellow (count_yellow),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .fault        (fault)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: scan position is time since reset modulo the scan
  // period; blink phase is derived from how long yellow has been held.
  initial begin : monitor
    int         pos, run, v;
    logic [2:0] lm;
    logic [4:0] cr, cg, cy;
    logic       s_rst;
    logic [2:0] s_l;
    logic [4:0] s_cr, s_cg, s_cy;
    logic       onehot;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_fault;
    pos = 0; run = 0; lm = '0; cr = '0; cg = '0; cy = '0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_l   = {red, green, yellow};
      s_cr  = count_red;
      s_cg  = count_green;
      s_cy  = count_yellow;
      if (!s_rst) begin
        e_seg = 7'h7F; e_an = 2'b11; e_fault = 1'b0;
        pos = 0; run = 0; lm = '0; cr = '0; cg = '0; cy = '0;
      end else begin
        onehot = (lm == 3'b100) || (lm == 3'b010) || (lm == 3'b001);
        v = (lm == 3'b100) ? int'(cr) : (lm == 3'b010) ? int'(cg) : int'(cy);
        if (pos < R) e_an = 2'b10;
        else if (pos == R) e_an = 2'b11;
        else if (pos <= 2 * R) e_an = 2'b01;
        else e_an = 2'b11;
        if (e_an == 2'b11) e_seg = 7'h7F;
        else if (!onehot) e_seg = 7'b0111111;
        else if (lm == 3'b001 && (((run - 1) / B) % 2) == 1) e_seg = 7'h7F;
        else if (e_an == 2'b10) e_seg = digit_seg(v % 10);
        else e_seg = (v / 10 == 0) ? 7'h7F : digit_seg(v / 10);
        e_fault = !onehot;
        lm = s_l; cr = s_cr; cg = s_cg; cy = s_cy;
        pos = (pos + 1) % P;
        run = (lm == 3'b001) ? run + 1 : 0;
      end
      #1;
      chk("mon_seg", {1'b0, seg_n}, {1'b0, e_seg});
      chk("mon_an", {6'b0, an_n}, {6'b0, e_an});
      chk("mon_fault", {7'b0, fault}, {7'b0, e_fault});
    end
  end

  task automatic set_lights(input logic r, input logic g, input logic y);
    red = r; green = g; yellow = y;
  endtask

  // Waits out the latency, then checks the first cycle showing slot an_t.
  task automatic expect_slot(input string nm, input logic [1:0] an_t, input logic [6:0] seg_t);
    bit found = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12 && !found; i++) begin
      if (an_n == an_t) begin
        chk(nm, {1'b0, seg_n}, {1'b0, seg_t});
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL %s: slot %b never seen", nm, an_t);
    end
  endtask

  // Inputs were just changed to yellow/3 at a negedge.
  task automatic blink_window(input string nm);
    @(negedge clk);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (an_n == 2'b10) chk({nm, "_on"}, {1'b0, seg_n}, 8'h30);
    end
    for (int k = 10; k <= 17; k++) begin
      @(negedge clk);
      chk({nm, "_off"}, {1'b0, seg_n}, 8'h7F);
    end
  endtask

  initial begin : stim
    int   len, per;
    bit   found;
    logic [1:0] prev;
    rst = 1'b0;
    set_lights(1, 0, 1);
    count_red = 5'd17; count_green = 5'd4; count_yellow = 5'd29;
    repeat (3) begin
      @(negedge clk);
      chk("rst_seg", {1'b0, seg_n}, 8'h7F);
      chk("rst_an", {6'b0, an_n}, 8'h03);
      chk("rst_fault", {7'b0, fault}, 8'h00);
    end

    rst = 1'b1;
    set_lights(1, 0, 0);
    count_red = 5'd25;
    expect_slot("red25_units", 2'b10, 7'b0010010);
    expect_slot("red25_tens", 2'b01, 7'b0100100);
    expect_slot("red25_gap", 2'b11, 7'h7F);
    chk("red25_fault", {7'b0, fault}, 8'h00);
    // Scan period: negedges between successive entries into the units slot.
    found = 0; per = 0; prev = an_n;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (an_n == 2'b10 && prev != 2'b10) begin
        if (per == 0) per = 1;
        else found = 1;
      end else if (per > 0) begin
        per++;
      end
      prev = an_n;
    end
    chk("scan_period", 8'(per), 8'd10);

    set_lights(0, 1, 0);
    count_green = 5'd7;
    expect_slot("green7_units", 2'b10, 7'b1111000);
    expect_slot("green7_tens", 2'b01, 7'h7F);
    count_green = 5'd0;
    expect_slot("green0_units", 2'b10, 7'b1000000);

    @(negedge clk);
    set_lights(0, 0, 1);
    count_yellow = 5'd3;
    blink_window("blink1");
    set_lights(1, 0, 0);
    count_red = 5'd5;
    repeat (3) @(negedge clk);
    set_lights(0, 0, 1);
    blink_window("blink2");

    set_lights(1, 1, 0);
    expect_slot("fault_units", 2'b10, 7'b0111111);
    expect_slot("fault_tens", 2'b01, 7'b0111111);
    chk("fault_on", {7'b0, fault}, 8'h01);
    set_lights(1, 0, 0);
    repeat (2) @(negedge clk);
    chk("fault_off", {7'b0, fault}, 8'h00);

    // Reset in the second S_TENS cycle while blink is OFF: the output then
    // shows the first tens cycle, blanked although tens = 1.
    set_lights(0, 0, 1);
    count_yellow = 5'd13;
    found = 0;
    @(negedge clk);
    prev = an_n;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      if (i > 2 && an_n == 2'b01 && prev == 2'b11 && seg_n == 7'h7F) found = 1;
      prev = an_n;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL midscan_search: tens/off point not reached");
    end else begin
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_seg", {1'b0, seg_n}, 8'h7F);
      chk("midrst_an", {6'b0, an_n}, 8'h03);
      chk("midrst_fault", {7'b0, fault}, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_restart_an", {6'b0, an_n}, 8'h02);
    end

    set_lights(1, 0, 0);
    for (int v = 0; v < 32; v++) begin
      count_red = 5'(v);
      if (v == 31) begin
        expect_slot("red31_units", 2'b10, 7'b1111001);
        expect_slot("red31_tens", 2'b01, 7'b0110000);
      end else if (v == 10) begin
        expect_slot("red10_units", 2'b10, 7'b1000000);
        expect_slot("red10_tens", 2'b01, 7'b1111001);
      end else begin
        repeat (12) @(negedge clk);
      end
    end

    for (int seg = 0; seg < 150; seg++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 2) set_lights(1, 0, 0);
      else if (sel <= 4) set_lights(0, 1, 0);
      else if (sel <= 7) set_lights(0, 0, 1);
      else if (sel == 8) set_lights(0, 0, 0);
      else set_lights(1'($urandom), 1'($urandom), 1'($urandom));
      count_red = 5'($urandom); count_green = 5'($urandom); count_yellow = 5'($urandom);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) count_yellow = 5'($urandom);
        rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      end
      rst = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_countdown_display.md
# traffic_countdown_display

Drives a two-digit, common-anode, seven-segment display from the traffic-light controller's outputs, downstream of it. Each cycle it registers the light state and the three per-light countdowns, selects the countdown of the active light and converts it to two decimal digits. It time-multiplexes the digits with a one-cycle ghosting gap between them, blinks the display during yellow, and shows a fault pattern when the light state is illegal.

## Interface
- `REFRESH_DIV`, default 4: clock cycles each digit is driven per scan slot; legal range ≥ 1.
- `BLINK_DIV`, default 8: clock cycles per blink half-period during yellow; legal range ≥ 1.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-low (asserted when 0).
- `red`, `green`, `yellow` input 1 each: light state from the controller; exactly one is high in legal operation.
- `count_red`, `count_green`, `count_yellow` input 5 each: remaining seconds for each light, unsigned, 0..31.
- `seg_n` output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an_n` output 2: digit enables, active-low, registered; bit 0 is units, bit 1 is tens.
- `fault` output 1: high while the sampled light state is not one-hot; registered.

## Operation
- **Input stage**: `red`/`green`/`yellow` and the three counts are registered every cycle.
- **Value select**, from the registered copies:
  - red → `count_red`; green → `count_green`; yellow → `count_yellow`.
  - Anything not exactly one-hot (zero or several lights high) is a fault.
- **BCD conversion** of the 5-bit value v:
  - tens = 3 if v ≥ 30, 2 if v ≥ 20, 1 if v ≥ 10, else 0.
  - units = v − 10·tens. Both are 4 bits.
- **Leading-zero suppression**: the tens digit is blank when tens = 0. Units always shows, including 0.
- **Scan FSM**, states `S_UNITS` → `S_GAP1` → `S_TENS` → `S_GAP2` → `S_UNITS`:
  - `S_UNITS` and `S_TENS` each last `REFRESH_DIV` cycles; each gap lasts 1 cycle.
  - `an_n`: `2'b10` in `S_UNITS`, `2'b01` in `S_TENS`, `2'b11` in both gaps.
  - A dwell counter sized for `REFRESH_DIV` − 1 is cleared on every state change.
- **Blink**, active only while registered yellow is high and there is no fault:
  - A counter counts 0..`BLINK_DIV`−1 and toggles `phase` on wrap.
  - `phase` = ON shows the digits; `phase` = OFF forces `seg_n = 7'h7F` while `an_n` keeps scanning.
  - Counter and phase restart at 0/ON on the first registered cycle of yellow.
  - While yellow is not active, the counter is held at 0 and the phase at ON.
- **Fault**: both digits show a dash (`7'b0111111`, g only) and `fault` = 1. Blink does not apply.
- **Segment codes** (active-low):
  - 0 = `1000000`, 1 = `1111001`, 2 = `0100100`, 3 = `0110000`, 4 = `0011001`,
  - 5 = `0010010`, 6 = `0000010`, 7 = `1111000`, 8 = `0000000`, 9 = `0010000`,
  - blank = `1111111`.

## Timing
- **Reset values**: `seg_n` = `7'h7F`, `an_n` = `2'b11`, `fault` = 0; FSM in `S_UNITS` with dwell counter 0; blink counter 0, phase ON; input registers 0.
  - Assertion mid-scan or mid-blink returns everything to these values on the next edge, with no partial completion.
- **First cycle after release**: the FSM is in `S_UNITS`. Outputs show the decode of the input registers, which are still 0 (fault, dash) until the first sample lands.
- **Latency**: input change → input register (edge 1) → `seg_n`/`an_n`/`fault` (edge 2). Total 2 cycles, provided the affected digit is the one selected on edge 2.
- `an_n` and `seg_n` change on the same edge. In gap cycles `seg_n` is `7'h7F`.
- **Scan period** = 2·`REFRESH_DIV` + 2 cycles (10 at the defaults).
- **Blink period** = 2·`BLINK_DIV` cycles. It is independent of the scan and does not align to it.
- **Light change**: takes effect after the same 2-cycle latency. A change from yellow to another light cancels blink on the same edge as the new value appears.

## Structure
- **Package `traffic_pkg`**:
  - Scan state enum (`S_UNITS`, `S_GAP1`, `S_TENS`, `S_GAP2`).
  - Segment constants `SEG_BLANK`, `SEG_DASH` and the 0–9 digit codes.
  - Count width constant `CNT_W = 5`.
- **Sub-module `seg7_decode`**: combinational, 4-bit BCD plus a blank flag in, 7-bit active-low segments out. Instantiated once and fed by a mux on the scan state.

## Test plan
- **Reset**: hold `rst` = 0 for 3 cycles with arbitrary inputs → `seg_n` = `7F`, `an_n` = `11`, `fault` = 0 throughout. Then release with red = 1, `count_red` = 25: within 2 cycles units slot shows `0010010`, tens slot shows `0100100`, gaps show `an_n` = `11`, scan period 10 cycles.
- **Leading zero**: green = 1, `count_green` = 7 → units `1111000`, tens slot `seg_n` = `7F`. `count_green` = 0 → units `1000000`.
- **Blink**: yellow = 1, `count_yellow` = 3, `BLINK_DIV` = 8 → units `0110000` for 8 cycles, blank for 8, repeating; `an_n` keeps scanning. Toggle yellow off then on → phase restarts ON.
- **Fault**: red = green = 1 → after 2 cycles `fault` = 1 and both slots show `0111111`. Return to red only → `fault` = 0 after 2 cycles.
- **Reset mid-scan**: assert `rst` in the 2nd cycle of `S_TENS` during a yellow OFF phase → next edge gives reset values; after release the scan restarts in `S_UNITS`.
- **Full range**: sweep `count_red` 0..31 → tens/units match the BCD rule, e.g. 31 → `0110000`/`1111001`, 10 → `1111001`/`1000000`.
